serial_subtractor: RTL



---
 rtl/serial_subtractor_pkg.sv | 16 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 105 ++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor and future serial CNU arithmetic.
// The FSM state encoding and the bit-counter width rule live here.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // CNT_W for a given WIDTH: enough bits to count 0..WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: DIFF = (A - B) mod 2^WIDTH, LSB first, one bit per clock.
// Operands and result move through valid/ready handshakes; BORROW flags A < B.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] DIFF,
    output logic             BORROW
);

    localparam int             CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow;
    logic             d;
    logic             bo;
    logic             accept;
    logic             last_bit;

    assign accept   = (state == IDLE) && in_valid && in_ready;
    assign last_bit = (state == RUN) && (cnt == LAST);

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
        .d    (d),
        .bout (bo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            IDLE:    if (accept)         state_next = RUN;
            RUN:     if (cnt == LAST)    state_next = DONE;
            DONE:    if (out_ready)      state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // in_ready is registered so it stays low throughout reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these are a handful of flops, not a memory, so each one gets an explicit reset value.
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            cnt       <= '0;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            borrow    <= 1'b0;
            DIFF      <= '0;
            BORROW    <= 1'b0;
        end else begin
            in_ready <= (state_next == IDLE);
            if (accept) begin
                a_sr   <= A;
                b_sr   <= B;
                res_sr <= '0;
                borrow <= 1'b0;
                cnt    <= '0;
            end else if (state == RUN) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                res_sr <= {d, res_sr[WIDTH-1:1]};
                borrow <= bo;
                if (last_bit) begin
                    DIFF      <= {d, res_sr[WIDTH-1:1]};
                    BORROW    <= bo;
                    out_valid <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if ((state == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
